// File: rtl/vrc3x_pkg.sv
// Shared constants and types for the VRC3-class mapper core (chip_vrc3x).
package vrc3x_pkg;

  localparam logic [2:0] REG_LATCH0 = 3'd0;
  localparam logic [2:0] REG_LATCH1 = 3'd1;
  localparam logic [2:0] REG_LATCH2 = 3'd2;
  localparam logic [2:0] REG_LATCH3 = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_ACK    = 3'd5;
  localparam logic [2:0] REG_BANK   = 3'd7;

  localparam int CTRL_EA = 0;
  localparam int CTRL_E  = 1;
  localparam int CTRL_M  = 2;
  localparam int CTRL_O  = 3;

  localparam logic [7:0] SST_LATCH_LO = 8'd0;
  localparam logic [7:0] SST_LATCH_HI = 8'd1;
  localparam logic [7:0] SST_CNT_LO   = 8'd2;
  localparam logic [7:0] SST_CNT_HI   = 8'd3;
  localparam logic [7:0] SST_CTRL     = 8'd4;
  localparam logic [7:0] SST_BANK     = 8'd5;
  localparam logic [7:0] SST_PRESC    = 8'd6;

  // Field order puts ea at bit 0 so the struct lines up with the ctrl write data.
  typedef struct packed {
    logic o;
    logic m;
    logic e;
    logic ea;
  } ctrl_t;

endpackage

// File: rtl/vrc3x_irq_cnt.sv
// CPU-cycle IRQ counter: prescaler, 8/16-bit counter with reload, one-shot and irq_n.
// Save-state access is built only when VRC3X_SST_EN is defined.
module vrc3x_irq_cnt
  import vrc3x_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2_fall,
  input  logic       wr_en,
  input  logic [2:0] wr_reg,
  input  logic [3:0] wr_nib,
`ifdef VRC3X_SST_EN
  input  logic [7:0] sst_addr,
  input  logic       sst_we,
  input  logic [7:0] sst_wdat,
  output logic [7:0] sst_rdat,
`endif
  output logic       irq_n
);

  localparam logic [7:0] PMAX = 8'(PRESCALE - 1);

  logic [15:0] latch, counter, cnt_nxt;
  logic [7:0]  presc;
  ctrl_t       ctrl;
  logic        wr_ctrl, wr_ack, step, wrap, ovf;

  assign wr_ctrl = wr_en && (wr_reg == REG_CTRL);
  assign wr_ack  = wr_en && (wr_reg == REG_ACK);
  // A ctrl/ack write on the same M2 fall swallows that fall's tick entirely.
  assign step    = m2_fall && ctrl.e && !wr_ctrl && !wr_ack;
  assign wrap    = (presc == PMAX);
  assign ovf     = ctrl.m ? (counter[7:0] == 8'hFF) : (counter == 16'hFFFF);

  always_comb begin
    cnt_nxt = counter + 16'd1;
    if (ctrl.m) cnt_nxt = {counter[15:8], counter[7:0] + 8'd1};
    if (ovf)    cnt_nxt = ctrl.m ? {counter[15:8], latch[7:0]} : latch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch   <= '0;
      counter <= '0;
      presc   <= '0;
      ctrl    <= '0;
      irq_n   <= 1'b1;
    end else begin
      if (wr_en) begin
        case (wr_reg)
          REG_LATCH0: latch[3:0]   <= wr_nib;
          REG_LATCH1: latch[7:4]   <= wr_nib;
          REG_LATCH2: latch[11:8]  <= wr_nib;
          REG_LATCH3: latch[15:12] <= wr_nib;
          REG_CTRL: begin
            ctrl  <= ctrl_t'(wr_nib);
            irq_n <= 1'b1;
            presc <= '0;
            if (wr_nib[CTRL_E]) counter <= latch;
          end
          REG_ACK: begin
            irq_n  <= 1'b1;
            ctrl.e <= ctrl.ea;
          end
          default: ;
        endcase
      end
      if (step) begin
        presc <= wrap ? 8'd0 : presc + 8'd1;
        if (wrap) begin
          counter <= cnt_nxt;
          if (ovf) begin
            irq_n <= 1'b0;
            if (ctrl.o) ctrl.e <= 1'b0;
          end
        end
      end
`ifdef VRC3X_SST_EN
      if (sst_we) begin
        case (sst_addr)
          SST_LATCH_LO: latch[7:0]    <= sst_wdat;
          SST_LATCH_HI: latch[15:8]   <= sst_wdat;
          SST_CNT_LO:   counter[7:0]  <= sst_wdat;
          SST_CNT_HI:   counter[15:8] <= sst_wdat;
          SST_CTRL: begin
            ctrl  <= ctrl_t'(sst_wdat[3:0]);
            irq_n <= !sst_wdat[4];
          end
          SST_PRESC:    presc <= sst_wdat;
          default: ;
        endcase
      end
`endif
    end
  end

`ifdef VRC3X_SST_EN
  logic unused_sst;
  assign unused_sst = ^sst_wdat[7:5];

  always_comb begin
    sst_rdat = 8'hFF;
    case (sst_addr)
      SST_LATCH_LO: sst_rdat = latch[7:0];
      SST_LATCH_HI: sst_rdat = latch[15:8];
      SST_CNT_LO:   sst_rdat = counter[7:0];
      SST_CNT_HI:   sst_rdat = counter[15:8];
      SST_CTRL:     sst_rdat = {3'b000, !irq_n, ctrl};
      SST_PRESC:    sst_rdat = presc;
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/chip_vrc3x.sv
// VRC3-class mapper top: M2 synchroniser, bus capture, PRG/WRAM decode, bank register.
// Optional save-state port enabled by VRC3X_SST_EN.
module chip_vrc3x
  import vrc3x_pkg::*;
#(
  parameter int PRG_W    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_m2,
  input  logic             cpu_rw,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data,
  output logic             irq_n,
  output logic             wram_ce_n,
  output logic             prg_ce_n,
`ifdef VRC3X_SST_EN
  input  logic [7:0]       sst_addr,
  input  logic             sst_we,
  input  logic [7:0]       sst_wdat,
  output logic [7:0]       sst_rdat,
`endif
  output logic [PRG_W-1:0] prg_addr
);

  logic             m2_q1, m2_s, m2_s_d, m2_fall;
  logic [3:0]       cap_addr;
  logic             cap_rw;
  logic [7:0]       cap_data;
  logic [PRG_W-1:0] bank;
  logic             wr_en;
  logic             unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_q1  <= 1'b0;
      m2_s   <= 1'b0;
      m2_s_d <= 1'b0;
    end else begin
      m2_q1  <= cpu_m2;
      m2_s   <= m2_q1;
      m2_s_d <= m2_s;
    end
  end

  assign m2_fall = m2_s_d && !m2_s;

  // Bus is sampled throughout the synchronised high phase; the last sample commits at the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      cap_rw   <= 1'b1;
      cap_data <= '0;
    end else if (m2_s) begin
      cap_addr <= cpu_addr[15:12];
      cap_rw   <= cpu_rw;
      cap_data <= cpu_data;
    end
  end

  assign wr_en = m2_fall && !cap_rw && cap_addr[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else begin
      if (wr_en && (cap_addr[2:0] == REG_BANK)) bank <= cap_data[PRG_W-1:0];
`ifdef VRC3X_SST_EN
      if (sst_we && (sst_addr == SST_BANK)) bank <= sst_wdat[PRG_W-1:0];
`endif
    end
  end

  assign wram_ce_n = !(m2_s && (cpu_addr[15:13] == 3'b011));
  assign prg_ce_n  = !cpu_addr[15];
  assign prg_addr  = cpu_addr[14] ? '1 : bank;

  assign unused_bits = ^{cpu_addr[11:0], cap_data};

`ifdef VRC3X_SST_EN
  logic [7:0] cnt_rdat;
  assign sst_rdat = (sst_addr == SST_BANK) ? 8'(bank) : cnt_rdat;
`endif

  vrc3x_irq_cnt #(.PRESCALE(PRESCALE)) u_irq (
    .clk      (clk),
    .rst_n    (rst_n),
    .m2_fall  (m2_fall),
    .wr_en    (wr_en),
    .wr_reg   (cap_addr[2:0]),
    .wr_nib   (cap_data[3:0]),
`ifdef VRC3X_SST_EN
    .sst_addr (sst_addr),
    .sst_we   (sst_we),
    .sst_wdat (sst_wdat),
    .sst_rdat (cnt_rdat),
`endif
    .irq_n    (irq_n)
  );

endmodule

// File: tb/tb_chip_vrc3x.sv
// Directed bench for chip_vrc3x: one PRESCALE=1 and one PRESCALE=4 instance on a shared CPU bus.
module tb_chip_vrc3x;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_m2, cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        irq_n, wram_ce_n, prg_ce_n;
  logic        irq4_n, wram4_ce_n, prg4_ce_n;
  logic [2:0]  prg_addr, prg4_addr;
  logic [7:0]  sst_addr, sst_wdat;
  logic        sst_we;
  logic [7:0]  sst_rdat, sst_rdat4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  chip_vrc3x #(.PRG_W(3), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .irq_n(irq_n), .wram_ce_n(wram_ce_n), .prg_ce_n(prg_ce_n),
`ifdef VRC3X_SST_EN
    .sst_addr(sst_addr), .sst_we(sst_we), .sst_wdat(sst_wdat), .sst_rdat(sst_rdat),
`endif
    .prg_addr(prg_addr)
  );

  chip_vrc3x #(.PRG_W(3), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .irq_n(irq4_n), .wram_ce_n(wram4_ce_n), .prg_ce_n(prg4_ce_n),
`ifdef VRC3X_SST_EN
    .sst_addr(sst_addr), .sst_we(sst_we), .sst_wdat(sst_wdat), .sst_rdat(sst_rdat4),
`endif
    .prg_addr(prg4_addr)
  );

`ifndef VRC3X_SST_EN
  assign sst_rdat  = 8'hFF;
  assign sst_rdat4 = 8'hFF;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full M2 period; inputs change on negedge so nothing moves at the active edge.
  task automatic m2_cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_rw = rw; cpu_data = d; cpu_m2 = 1'b1;
    repeat (4) @(negedge clk);
    cpu_m2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) m2_cyc(16'h0000, 1'b1, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    m2_cyc(a, 1'b0, d);
  endtask

  task automatic set_latch(input logic [15:0] v);
    wr(16'h8000, {4'h0, v[3:0]});
    wr(16'h9000, {4'h0, v[7:4]});
    wr(16'hA000, {4'h0, v[11:8]});
    wr(16'hB000, {4'h0, v[15:12]});
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [7:0] idx, input bit four, input logic [7:0] exp);
`ifdef VRC3X_SST_EN
    sst_addr = idx;
    #1;
    chk(tag, {8'h00, four ? sst_rdat4 : sst_rdat}, {8'h00, exp});
`endif
  endtask

  initial begin
    rst_n = 1'b0; cpu_m2 = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00;
    sst_addr = 8'h00; sst_we = 1'b0; sst_wdat = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    cpu_addr = 16'h8000; #1;
    chk("rst_irq", {15'h0, irq_n}, 16'h1);
    chk("rst_irq4", {15'h0, irq4_n}, 16'h1);
    chk("rst_bank", {13'h0, prg_addr}, 16'h0);
    chk("rst_prg_ce", {15'h0, prg_ce_n}, 16'h0);
    chk("rst_wram_ce", {15'h0, wram_ce_n}, 16'h1);
    peek("rst_sst_ctrl", 8'd4, 1'b0, 8'h00);
    peek("rst_sst_cnt", 8'd2, 1'b0, 8'h00);
    peek("rst_sst_bad", 8'd7, 1'b0, 8'hFF);

    // bank register and decode
    wr(16'hF000, 8'h05);
    cpu_addr = 16'h9234; #1;
    chk("bank_lo", {13'h0, prg_addr}, 16'h5);
    chk("bank_ce", {15'h0, prg_ce_n}, 16'h0);
    cpu_addr = 16'hC000; #1;
    chk("bank_fixed", {13'h0, prg_addr}, 16'h7);
    cpu_addr = 16'h6000; #1;
    chk("wram_prg_ce", {15'h0, prg_ce_n}, 16'h1);
    chk("wram_m2lo", {15'h0, wram_ce_n}, 16'h1);
    cpu_m2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("wram_m2hi", {15'h0, wram_ce_n}, 16'h0);
    cpu_m2 = 1'b0;
    repeat (4) @(negedge clk);
    peek("sst_bank", 8'd5, 1'b0, 8'h05);

    // 16-bit IRQ: FFFC -> overflow on the 4th M2 fall
    set_latch(16'hFFFC);
    wr(16'hC000, 8'h02);
    idle(3);
    chk("c16_pre", {15'h0, irq_n}, 16'h1);
    idle(1);
    chk("c16_irq", {15'h0, irq_n}, 16'h0);
    peek("c16_rl_lo", 8'd2, 1'b0, 8'hFC);
    peek("c16_rl_hi", 8'd3, 1'b0, 8'hFF);
    wr(16'hD000, 8'h00);
    chk("c16_ack", {15'h0, irq_n}, 16'h1);

    // 8-bit mode: 12FE -> overflow on the 2nd fall, high byte held
    set_latch(16'h12FE);
    wr(16'hC000, 8'h06);
    idle(1);
    chk("c8_pre", {15'h0, irq_n}, 16'h1);
    peek("c8_hi_a", 8'd3, 1'b0, 8'h12);
    idle(1);
    chk("c8_irq", {15'h0, irq_n}, 16'h0);
    peek("c8_hi_b", 8'd3, 1'b0, 8'h12);
    peek("c8_lo", 8'd2, 1'b0, 8'hFE);
    wr(16'hD000, 8'h00);
    chk("c8_ack", {15'h0, irq_n}, 16'h1);

    // one-shot: PRESCALE=1 fires on the 1st fall, PRESCALE=4 on the 4th
    do_reset();
    set_latch(16'hFFFF);
    wr(16'hC000, 8'h0A);
    idle(1);
    chk("os_p1_irq", {15'h0, irq_n}, 16'h0);
    idle(2);
    chk("os_p4_pre", {15'h0, irq4_n}, 16'h1);
    idle(1);
    chk("os_p4_irq", {15'h0, irq4_n}, 16'h0);
    peek("os_p4_ctrl", 8'd4, 1'b1, 8'h18);
    idle(100);
    chk("os_p4_hold", {15'h0, irq4_n}, 16'h0);
    peek("os_p4_lo", 8'd2, 1'b1, 8'hFF);
    peek("os_p4_hi", 8'd3, 1'b1, 8'hFF);
    peek("os_p4_presc", 8'd6, 1'b1, 8'h00);
    wr(16'hD000, 8'h00);
    chk("os_p4_ack", {15'h0, irq4_n}, 16'h1);
    idle(8);
    chk("os_p4_frozen", {15'h0, irq4_n}, 16'h1);

    // ctrl write on the overflowing fall beats the tick
    do_reset();
    set_latch(16'hFFFD);
    wr(16'hC000, 8'h02);
    idle(2);
    wr(16'hC000, 8'h02);
    chk("col_irq", {15'h0, irq_n}, 16'h1);
    peek("col_cnt", 8'd2, 1'b0, 8'hFD);
    idle(2);
    chk("col_pre", {15'h0, irq_n}, 16'h1);
    idle(1);
    chk("col_irq2", {15'h0, irq_n}, 16'h0);

    // async reset during a bank write
    wr(16'hF000, 8'h05);
    @(negedge clk);
    cpu_addr = 16'hF000; cpu_rw = 1'b0; cpu_data = 8'h03; cpu_m2 = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("rr_irq_async", {15'h0, irq_n}, 16'h1);
    @(negedge clk); cpu_m2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cpu_addr = 16'h8000; cpu_rw = 1'b1; #1;
    chk("rr_bank", {13'h0, prg_addr}, 16'h0);
    chk("rr_irq", {15'h0, irq_n}, 16'h1);

`ifdef VRC3X_SST_EN
    @(negedge clk);
    sst_addr = 8'd5; sst_wdat = 8'h02; sst_we = 1'b1;
    @(negedge clk);
    sst_we = 1'b0; #1;
    chk("sst_wr_bank", {13'h0, prg_addr}, 16'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_vrc3x.md
Name: chip_vrc3x

Overview:
- Parametrised successor to the VRC3-class mapper core: PRG banking, WRAM decode and a programmable CPU-cycle IRQ counter.
- Generalised PRG bank width and an IRQ prescaler; adds a one-shot IRQ mode the original chip lacks.
- Runs on the fast system clock. M2 is sampled and edge-detected internally.
- Instantiated by mapper wrappers, which drive mao.prg/srm and mao.irq from its outputs.

Parameters:
- PRG_W, 3, switchable PRG bank register width (1..8); the PRG window is 2^PRG_W 16 KB banks.
- PRESCALE, 1, M2 falls per counter tick (1..256). The prescaler is 8 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_m2  in  1  CPU M2, asynchronous to clk
- cpu_rw  in  1  CPU read/write (1 = read)
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data
- irq_n  out  1  IRQ request, active low
- wram_ce_n  out  1  WRAM select $6000-$7FFF, active low
- prg_ce_n  out  1  PRG ROM select $8000-$FFFF, active low
- prg_addr  out  PRG_W  PRG address bits [PRG_W+13:14]
- sst_addr  in  8  save-state index (VRC3X_SST_EN only)
- sst_we  in  1  save-state write strobe (VRC3X_SST_EN only)
- sst_wdat  in  8  save-state write data (VRC3X_SST_EN only)
- sst_rdat  out  8  save-state read data (VRC3X_SST_EN only)

Behaviour:
- Reset values: irq_n=1; latch, counter, ctrl, bank and prescaler all 0.
- M2 handling:
  - 2-flop synchroniser gives m2_s; m2_fall is a 1-clk pulse when m2_s goes 1->0.
  - cpu_addr, cpu_rw and cpu_data are captured every clk while m2_s=1; the last captured values are used at m2_fall.
- Decode (combinational):
  - wram_ce_n = !(m2_s && addr[15:13]==3'b011).
  - prg_ce_n = !addr[15].
  - prg_addr = bank when addr[14]=0, all ones (fixed last bank) when addr[14]=1.
- Register writes commit at m2_fall when captured rw=0 and addr[15]=1. Decode uses addr[14:12]:
  - 000/001/010/011: latch nibble 0/1/2/3 <= data[3:0].
  - 100 ctrl: bit0 EA, bit1 E, bit2 M (8-bit mode), bit3 O (one-shot). Effects:
    - irq_n <= 1 and prescaler <= 0.
    - If new E=1, counter <= latch.
  - 101 ack: irq_n <= 1; E <= EA.
  - 110: no effect.
  - 111 bank: bank <= data[PRG_W-1:0].
- Tick:
  - On m2_fall with E=1 the prescaler increments.
  - When prescaler==PRESCALE-1 it wraps to 0 and the counter ticks. PRESCALE=1 gives a tick every M2.
- Counter, 16-bit mode (M=0):
  - counter==16'hFFFF: counter <= latch, irq_n <= 0.
  - Otherwise counter+1.
- Counter, 8-bit mode (M=1):
  - Only the low byte counts. low==8'hFF: low <= latch[7:0], irq_n <= 0.
  - The high byte is held in all cases.
- One-shot: O=1 at overflow also clears E. The reload still occurs; the counter then stays frozen.
- Simultaneous events: a ctrl or ack write at the same m2_fall as a tick wins; the tick is discarded, and so is any overflow that tick would cause.
- Held state:
  - irq_n stays low until a ctrl or ack write, or reset. Overflow while already low keeps it low.
  - Latch writes do not affect the running counter.
- Reset mid-operation: all state returns to reset values asynchronously. A pending write is dropped; the synchroniser clears to 0 and so generates no spurious m2_fall.

Optional Feature:
- Macro VRC3X_SST_EN.
- With it: sst ports are present.
  - Index map: 0 latch[7:0], 1 latch[15:8], 2 counter[7:0], 3 counter[15:8], 4 {3'b0,!irq_n,O,M,E,EA}, 5 bank zero-extended, 6 prescaler.
  - Other indexes read 8'hFF.
  - sst_we writes the indexed register on clk and takes priority over any simultaneous m2_fall update of that register.
- Without it: ports and logic are absent; state cannot be saved or restored.

Decomposition:
- Package vrc3x_pkg holds:
  - register decode constants (REG_LATCH0..3, REG_CTRL, REG_ACK, REG_BANK);
  - ctrl bit indices;
  - SST index constants;
  - a typedef struct for ctrl {ea,e,m,o}.
- Sub-module vrc3x_irq_cnt holds prescaler, counter, 8/16-bit overflow, reload, one-shot and irq_n. The top keeps the synchroniser, decode and bank register.

Test Plan:
- Bank: write $F000=8'h05 with PRG_W=3, read $9234 -> prg_addr=3'b101, prg_ce_n=0; read $C000 -> prg_addr=3'b111.
- 16-bit IRQ: latch=16'hFFFC, ctrl=8'h02 -> irq_n falls after exactly 4 M2 falls and the counter reloads to 16'hFFFC; write $D000 -> irq_n=1.
- 8-bit mode: latch=16'h12FE, ctrl=8'h06 -> IRQ after 2 M2 falls; the high byte reads 8'h12 throughout (SST index 3).
- One-shot with PRESCALE=4: latch=16'hFFFF, ctrl=8'h0A -> IRQ after 4 M2 falls, E=0 afterwards, the counter does not advance over 100 more M2 falls.
- Collision: on the M2 fall that would overflow, write $C000=8'h02 -> irq_n stays 1 and counter=latch.
- Reset: assert rst_n=0 while m2 is high mid-write to $F000 -> bank=0, irq_n=1, and no write occurs after release.
